instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Responder end of the instruction-fetch interface: accepts a byte address from the fetch stage, returns the 32-bit instruction after a fixed latency.
- Contents are loaded serially, one byte per beat, by a loader port after reset, before any fetch is served.
- Sits between the PC/fetch logic and the decode stage in the reduced RISC-V core.

Parameters:
- ADDR_WIDTH, 8, width of the fetch byte address.
- MEM_BYTES, 256, memory size in bytes; power of two, at most 2**ADDR_WIDTH.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..4.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset.
- load_valid  in  1  loader byte present.
- load_byte  in  8  byte to store at the current load pointer.
- load_done  in  1  loader finished; last beat or standalone.
- load_ready  out  1  loader beat accepted this cycle.
- req_valid  in  1  fetch request present.
- req_addr  in  ADDR_WIDTH  fetch byte address.
- req_ready  out  1  request accepted when req_valid && req_ready.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_instr  out  32  instruction, little-endian.
- rsp_err  out  1  misaligned request, qualified by rsp_valid.

Interface decision: one clock, clk; reset is synchronous and active-low on port rst.

Behaviour:
- States: LOAD, IDLE, BUSY.
- Reset (rst low at an edge):
  - state becomes LOAD; load pointer and latency counter become 0.
  - rsp_valid, rsp_err and rsp_instr become 0.
  - Memory array is not cleared; its contents are retained.
  - Reset overrides any in-flight request, and that request's response is never issued.
- LOAD:
  - load_ready = 1 and req_ready = 0. Requests are ignored and do not queue.
  - On load_valid: mem[ptr] <= load_byte, and ptr increments modulo MEM_BYTES.
  - Transition to IDLE when load_done is sampled high, or when the write fills the last byte (ptr = MEM_BYTES-1).
  - load_valid and load_done together: the byte is written, then the state goes to IDLE.
- IDLE:
  - req_ready = 1 and load_ready = 0; load inputs are ignored.
  - Acceptance at edge E latches the address and sets the counter to LATENCY-1. The state goes to BUSY, or directly to the response cycle when LATENCY = 1.
- BUSY:
  - req_ready = 0 except in the response cycle. The counter decrements each edge.
  - rsp_valid is high for exactly the one cycle starting LATENCY edges after E.
  - In the response cycle req_ready = 1. A new request may be accepted at the edge ending it, giving a sustained throughput of one fetch per LATENCY cycles.
  - Otherwise the state returns to IDLE.
- Data assembly:
  - rsp_instr = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, where a = latched address mod MEM_BYTES.
  - Each byte index wraps modulo MEM_BYTES.
- Misalignment:
  - Latched address bits [1:0] != 0 gives rsp_err = 1 and rsp_instr = 0, with the same latency.
  - rsp_err = 0 otherwise.
- Output hold: rsp_instr and rsp_err hold their last values when rsp_valid = 0. They are meaningful only when rsp_valid = 1.
- Address bits above log2(MEM_BYTES) are ignored.

Decomposition:
- Shared package imem_pkg:
  - state enum (LOAD, IDLE, BUSY);
  - INSTR_WIDTH = 32;
  - ALIGN_MASK = 2'b11.
- Sub-module byte_ram: MEM_BYTES x 8, one synchronous write port, four combinational read ports.
- The responder FSM, load pointer, latency counter and little-endian assembly live in the top module.

Test Plan:
- Load 0x13,0x00,0x00,0x00 then load_done; request addr 0x00 at edge E with LATENCY=2 -> rsp_valid only in cycle E+2; rsp_instr=0x00000013, rsp_err=0.
- Request addr 0x06 -> rsp_err=1, rsp_instr=0, same latency.
- MEM_BYTES=256, bytes 0xFC..0xFF = 11,22,33,44 and 0x00..0x03 = 55,66,77,88; request 0xFC -> 0x44332211. The next back-to-back request 0x00 is accepted in the response cycle -> 0x88776655 two cycles later.
- req_valid held high during LOAD -> req_ready=0, no rsp_valid. After load_done, the first response arrives LATENCY cycles after acceptance.
- Assert rst low in the cycle after acceptance (LATENCY=3) -> no rsp_valid is ever issued; state is LOAD; load_ready=1; previously loaded data is still readable after a fresh load_done.
- Write all 256 bytes without load_done -> automatic transition to IDLE after the 256th beat; load_ready=0 on the next cycle.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory responder.
//   state_e       : responder state (LOAD, IDLE, BUSY)
//   INSTR_WIDTH   : width of an assembled instruction word
//   ALIGN_MASK    : low address bits that must be zero for a word fetch
//   is_misaligned : true when a byte address is not word aligned
package imem_pkg;

    localparam int         INSTR_WIDTH = 32;
    localparam logic [1:0] ALIGN_MASK  = 2'b11;

    typedef enum logic [1:0] {
        LOAD = 2'b00,
        IDLE = 2'b01,
        BUSY = 2'b10
    } state_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return |(addr_lsb & ALIGN_MASK);
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte-wide storage for the instruction memory responder.
// One synchronous write port and four combinational read ports, so that a
// full little-endian word can be assembled in a single cycle. The array has
// no reset: its contents survive a responder reset.
//   clk            : clock
//   wr_en          : write strobe
//   wr_addr        : byte index to write
//   wr_data        : byte to write
//   rd_addr0..3    : byte indices to read
//   rd_data0..3    : bytes read combinationally
module byte_ram #(
    parameter int MEM_BYTES = 256,
    parameter int IDX_W     = $clog2(MEM_BYTES)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W-1:0] rd_addr0,
    input  logic [IDX_W-1:0] rd_addr1,
    input  logic [IDX_W-1:0] rd_addr2,
    input  logic [IDX_W-1:0] rd_addr3,
    output logic [7:0]       rd_data0,
    output logic [7:0]       rd_data1,
    output logic [7:0]       rd_data2,
    output logic [7:0]       rd_data3
);

    logic [7:0] mem_r [0:MEM_BYTES-1];

    // Synchronous byte write; the array is deliberately never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data0 = mem_r[rd_addr0];
    assign rd_data1 = mem_r[rd_addr1];
    assign rd_data2 = mem_r[rd_addr2];
    assign rd_data3 = mem_r[rd_addr3];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: serially loaded byte memory that answers
// fetch requests with a little-endian 32-bit word after LATENCY cycles.
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-low reset
//   load_valid : loader byte present
//   load_byte  : byte to store at the load pointer
//   load_done  : loader finished (last beat or standalone)
//   load_ready : loader beat accepted this cycle
//   req_valid  : fetch request present
//   req_addr   : fetch byte address
//   req_ready  : request accepted when req_valid && req_ready
//   rsp_valid  : one-cycle response strobe
//   rsp_instr  : fetched instruction, little-endian
//   rsp_err    : misaligned request, qualified by rsp_valid
module instr_mem_responder
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_BYTES  = 256,
    parameter int LATENCY    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    input  logic [7:0]             load_byte,
    input  logic                   load_done,
    output logic                   load_ready,
    input  logic                   req_valid,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [INSTR_WIDTH-1:0] rsp_instr,
    output logic                   rsp_err
);

    localparam int               IDX_W    = $clog2(MEM_BYTES);
    localparam int               CNT_W    = 2;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(MEM_BYTES - 1);

    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [IDX_W-1:0]       ptr_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [IDX_W-1:0]       addr_r;
    logic                   rsp_valid_r;
    logic [INSTR_WIDTH-1:0] rsp_instr_r;
    logic                   rsp_err_r;

    logic                   load_ready_s;
    logic                   req_ready_s;
    logic                   accept_s;
    logic                   wr_en_s;
    logic                   rsp_fire_s;
    logic [7:0]             rd_data0_s;
    logic [7:0]             rd_data1_s;
    logic [7:0]             rd_data2_s;
    logic [7:0]             rd_data3_s;

    // Byte indices wrap naturally in IDX_W bits, i.e. modulo MEM_BYTES.
    byte_ram #(
        .MEM_BYTES (MEM_BYTES),
        .IDX_W     (IDX_W)
    ) u_byte_ram (
        .clk      (clk),
        .wr_en    (wr_en_s),
        .wr_addr  (ptr_r),
        .wr_data  (load_byte),
        .rd_addr0 (addr_r),
        .rd_addr1 (addr_r + IDX_W'(1)),
        .rd_addr2 (addr_r + IDX_W'(2)),
        .rd_addr3 (addr_r + IDX_W'(3)),
        .rd_data0 (rd_data0_s),
        .rd_data1 (rd_data1_s),
        .rd_data2 (rd_data2_s),
        .rd_data3 (rd_data3_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. The BUSY cycle with a zero counter is the response
    // cycle: its ending edge raises rsp_valid and may accept the next request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            LOAD: begin
                if (load_done || (load_valid && (ptr_r == PTR_LAST))) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == CNT_ZERO) begin
                    if (req_valid) begin
                        state_nxt_s = BUSY;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = LOAD;
            end
        endcase
    end

    // Handshake and strobe decode from the registered state.
    always_comb begin
        load_ready_s = 1'b0;
        req_ready_s  = 1'b0;
        rsp_fire_s   = 1'b0;
        case (state_r)
            LOAD: begin
                load_ready_s = 1'b1;
            end
            IDLE: begin
                req_ready_s = 1'b1;
            end
            BUSY: begin
                if (cnt_r == CNT_ZERO) begin
                    req_ready_s = 1'b1;
                    rsp_fire_s  = 1'b1;
                end else begin
                    req_ready_s = 1'b0;
                    rsp_fire_s  = 1'b0;
                end
            end
            default: begin
                load_ready_s = 1'b0;
                req_ready_s  = 1'b0;
                rsp_fire_s   = 1'b0;
            end
        endcase
        accept_s = req_valid && req_ready_s;
        wr_en_s  = load_valid && load_ready_s;
    end

    // Load pointer, latched address, latency counter and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r       <= {IDX_W{1'b0}};
            cnt_r       <= CNT_ZERO;
            addr_r      <= {IDX_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_instr_r <= {INSTR_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            if (wr_en_s) begin
                ptr_r <= ptr_r + IDX_W'(1);
            end

            // Address bits above the memory index are dropped here.
            if (accept_s) begin
                addr_r <= req_addr[IDX_W-1:0];
                cnt_r  <= CNT_INIT;
            end else if ((state_r == BUSY) && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end

            rsp_valid_r <= rsp_fire_s;

            // Data and error only change on a response; otherwise they hold.
            if (rsp_fire_s) begin
                rsp_err_r <= is_misaligned(addr_r[1:0]);
                if (is_misaligned(addr_r[1:0])) begin
                    rsp_instr_r <= {INSTR_WIDTH{1'b0}};
                end else begin
                    rsp_instr_r <= {rd_data3_s, rd_data2_s, rd_data1_s, rd_data0_s};
                end
            end
        end
    end

    assign load_ready = load_ready_s;
    assign req_ready  = req_ready_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_instr  = rsp_instr_r;
    assign rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder. Expected responses come from
// a byte-array model of the memory and the fetch rules (little-endian word,
// index modulo memory size, zero data and error flag when misaligned).
module tb_instr_mem_responder;

    localparam int LAT   = 2;
    localparam int MBYTE = 256;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic [7:0]  load_byte;
    logic        load_done;
    logic        load_ready;
    logic        req_valid;
    logic [7:0]  req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_instr;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_mem [0:MBYTE-1];
    int         mptr;

    instr_mem_responder #(
        .ADDR_WIDTH (8),
        .MEM_BYTES  (MBYTE),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_done  (load_done),
        .load_ready (load_ready),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_instr  (rsp_instr),
        .rsp_err    (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference response: {err, instr}.
    function automatic logic [32:0] ref_rsp(input logic [7:0] addr);
        int          a;
        logic [31:0] w;
        a = int'(addr) % MBYTE;
        if ((int'(addr) % 4) != 0) return {1'b1, 32'h0};
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            w = w | (32'(model_mem[(a + k) % MBYTE]) << (8 * k));
        end
        return {1'b0, w};
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        tick();
        mptr = 0;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_rsp_instr", rsp_instr, 32'h0);
        check("rst_load_ready", 32'(load_ready), 32'h1);
        check("rst_req_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
    endtask

    task automatic load_beat(input logic [7:0] b);
        check("load_ready_on", 32'(load_ready), 32'h1);
        check("load_req_ready", 32'(req_ready), 32'h0);
        check("load_rsp_valid", 32'(rsp_valid), 32'h0);
        load_valid = 1'b1;
        load_byte  = b;
        tick();
        load_valid = 1'b0;
        model_mem[mptr] = b;
        mptr = (mptr + 1) % MBYTE;
    endtask

    task automatic load_done_only();
        check("done_load_ready", 32'(load_ready), 32'h1);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        check("done_load_ready_off", 32'(load_ready), 32'h0);
        check("done_req_ready", 32'(req_ready), 32'h1);
    endtask

    task automatic fetch(input logic [7:0] addr);
        logic [32:0] e;
        e = ref_rsp(addr);
        req_valid = 1'b1;
        req_addr  = addr;
        check("fetch_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        check("fetch_early", 32'(rsp_valid), 32'h0);
        for (int k = 1; k < LAT; k++) begin
            tick();
            check("fetch_early", 32'(rsp_valid), 32'h0);
        end
        tick();
        check("fetch_valid", 32'(rsp_valid), 32'h1);
        check("fetch_instr", rsp_instr, e[31:0]);
        check("fetch_err", 32'(rsp_err), 32'(e[32]));
        tick();
        check("fetch_strobe_end", 32'(rsp_valid), 32'h0);
        check("fetch_hold_instr", rsp_instr, e[31:0]);
        check("fetch_hold_err", 32'(rsp_err), 32'(e[32]));
    endtask

    initial begin
        logic [7:0]  a;
        logic [7:0]  prev;
        logic [32:0] e;

        rst        = 1'b0;
        load_valid = 1'b0;
        load_byte  = 8'h00;
        load_done  = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 8'h00;
        mptr       = 0;
        tick();
        do_reset();

        // Request held during LOAD must be ignored; served after load_done.
        req_valid = 1'b1;
        req_addr  = 8'h00;
        load_beat(8'h13);
        load_beat(8'h00);
        load_beat(8'h00);
        load_beat(8'h00);
        load_done_only();
        fetch(8'h00);
        fetch(8'h06);

        // Full fill without load_done: automatic transition after last beat.
        do_reset();
        for (int i = 0; i < MBYTE; i++) begin
            case (i)
                0:       a = 8'h55;
                1:       a = 8'h66;
                2:       a = 8'h77;
                3:       a = 8'h88;
                252:     a = 8'h11;
                253:     a = 8'h22;
                254:     a = 8'h33;
                255:     a = 8'h44;
                default: a = 8'($urandom_range(0, 255));
            endcase
            load_beat(a);
        end
        check("fill_load_ready_off", 32'(load_ready), 32'h0);
        check("fill_req_ready", 32'(req_ready), 32'h1);

        // Wrapping fetch followed by a request accepted in the response cycle.
        req_valid = 1'b1;
        req_addr  = 8'hFC;
        tick();
        req_valid = 1'b0;
        check("b2b_busy_ready", 32'(req_ready), 32'h0);
        tick();
        check("b2b_rsp_cycle_ready", 32'(req_ready), 32'h1);
        check("b2b_not_yet", 32'(rsp_valid), 32'h0);
        req_valid = 1'b1;
        req_addr  = 8'h00;
        tick();
        req_valid = 1'b0;
        check("b2b_first_valid", 32'(rsp_valid), 32'h1);
        check("b2b_first_instr", rsp_instr, 32'h44332211);
        check("b2b_first_err", 32'(rsp_err), 32'h0);
        tick();
        check("b2b_gap", 32'(rsp_valid), 32'h0);
        tick();
        check("b2b_second_valid", 32'(rsp_valid), 32'h1);
        check("b2b_second_instr", rsp_instr, 32'h88776655);
        tick();
        check("b2b_end", 32'(rsp_valid), 32'h0);

        // Randomized single fetches with idle gaps.
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            fetch(a);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                check("idle_no_rsp", 32'(rsp_valid), 32'h0);
            end
        end

        // Randomized back-to-back burst at full throughput.
        prev = 8'h00;
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            check("burst_ready", 32'(req_ready), 32'h1);
            req_valid = 1'b1;
            req_addr  = a;
            tick();
            req_valid = 1'b0;
            if (i == 0) begin
                check("burst_first", 32'(rsp_valid), 32'h0);
            end else begin
                e = ref_rsp(prev);
                check("burst_valid", 32'(rsp_valid), 32'h1);
                check("burst_instr", rsp_instr, e[31:0]);
                check("burst_err", 32'(rsp_err), 32'(e[32]));
            end
            prev = a;
            for (int k = 1; k < LAT; k++) begin
                check("burst_busy_ready", 32'(req_ready), 32'h0);
                tick();
            end
        end
        tick();
        e = ref_rsp(prev);
        check("burst_last_valid", 32'(rsp_valid), 32'h1);
        check("burst_last_instr", rsp_instr, e[31:0]);
        check("burst_last_err", 32'(rsp_err), 32'(e[32]));
        tick();

        // Reset right after acceptance: the response must never appear.
        req_valid = 1'b1;
        req_addr  = 8'h10;
        check("abort_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        rst = 1'b0;
        tick();
        rst  = 1'b1;
        mptr = 0;
        for (int k = 0; k < 4; k++) begin
            check("abort_no_rsp", 32'(rsp_valid), 32'h0);
            check("abort_load_ready", 32'(load_ready), 32'h1);
            check("abort_req_ready", 32'(req_ready), 32'h0);
            tick();
        end
        load_done_only();
        fetch(8'h10);
        fetch(8'hFC);
        fetch(8'hFD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
